// File: rtl/nvdla_dbb_scheduler_pkg.sv
// nvdla_package: shared DBB scheduler types.
//   state_dbb_fsm_t  - scheduler FSM state encoding (legacy localparam constants)
//   ctrl_dbb_req_t   - captured DBB request (write flag, addr, len, id)
//   flags_dbb_rdat_t - per-cycle read beat flags
//   ctrl_dbb_wdat_t  - write burst progress flags
package nvdla_package;

    typedef logic [2:0] state_dbb_fsm_t;

    localparam state_dbb_fsm_t FSM_DBB_IDLE       = 3'd0;
    localparam state_dbb_fsm_t FSM_WRITE          = 3'd1;
    localparam state_dbb_fsm_t FSM_WAIT_WRITE     = 3'd2;
    localparam state_dbb_fsm_t FSM_WRITE_RESPONSE = 3'd3;
    localparam state_dbb_fsm_t FSM_READ           = 3'd4;
    localparam state_dbb_fsm_t FSM_WAIT_READ      = 3'd5;
    localparam state_dbb_fsm_t FSM_DBB_TERMINATE  = 3'd6;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [7:0]  id;
    } ctrl_dbb_req_t;

    typedef struct packed {
        logic hs;    // beat handshake this cycle
        logic last;  // current beat is beat len
    } flags_dbb_rdat_t;

    typedef struct packed {
        logic wack_seen;   // memory write-complete already observed
        logic beats_done;  // all len+1 beats accepted
    } ctrl_dbb_wdat_t;

endpackage

// File: rtl/nvdla_dbb_scheduler_rr_arbiter.sv
// nvdla_dbb_rr_arbiter: two-way round-robin grant between DBB write and read.
//   clk_i, rst_i           - clock, synchronous active-high reset
//   req_wr_i, req_rd_i     - requests (already qualified by the caller)
//   update_i, served_wr_i  - end-of-burst pulse and which side was served
//   gnt_wr_o, gnt_rd_o     - one-hot (or zero) grant
module nvdla_dbb_rr_arbiter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    input  logic update_i,
    input  logic served_wr_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    // 0 = write wins a tie, 1 = read wins a tie
    logic prio_rd_q, prio_rd_d;

    always_comb begin
        gnt_wr_o  = req_wr_i & (~req_rd_i | ~prio_rd_q);
        gnt_rd_o  = req_rd_i & (~req_wr_i | prio_rd_q);
        prio_rd_d = prio_rd_q;
        if (update_i) begin
            // Hand the next tie to the side that was not just served.
            prio_rd_d = served_wr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_rd_q <= 1'b0;
        end else begin
            prio_rd_q <= prio_rd_d;
        end
    end

endmodule

// File: rtl/nvdla_dbb_scheduler.sv
// nvdla_dbb_scheduler: serialises NVDLA DBB read/write bursts onto one memory channel.
//   wr_req_* / wdat_* / wrsp_*  - DBB write request, data and response
//   rd_req_* / rdat_*           - DBB read request and tagged read data
//   mem_cmd_* / mem_wdata_* / mem_wack_i / mem_rdata_* - memory-side channel
//   busy_o, done_o, err_o       - status: not idle, burst complete pulse, sticky last error
`ifndef NVDLA_PRIMARY_MEMIF_WIDTH
`define NVDLA_PRIMARY_MEMIF_WIDTH 64
`endif
module nvdla_dbb_scheduler #(
    parameter int unsigned DW = `NVDLA_PRIMARY_MEMIF_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic            wr_req_valid_i,
    output logic            wr_req_ready_o,
    input  logic [31:0]     wr_req_addr_i,
    input  logic [3:0]      wr_req_len_i,
    input  logic [7:0]      wr_req_id_i,
    input  logic            wdat_valid_i,
    output logic            wdat_ready_o,
    input  logic [DW-1:0]   wdat_data_i,
    input  logic [DW/8-1:0] wdat_strb_i,
    input  logic            wdat_last_i,
    output logic            wrsp_valid_o,
    input  logic            wrsp_ready_i,
    output logic [7:0]      wrsp_id_o,
    input  logic            rd_req_valid_i,
    output logic            rd_req_ready_o,
    input  logic [31:0]     rd_req_addr_i,
    input  logic [3:0]      rd_req_len_i,
    input  logic [7:0]      rd_req_id_i,
    output logic            rdat_valid_o,
    input  logic            rdat_ready_i,
    output logic [DW-1:0]   rdat_data_o,
    output logic            rdat_last_o,
    output logic [7:0]      rdat_id_o,
    output logic            mem_cmd_valid_o,
    input  logic            mem_cmd_ready_i,
    output logic            mem_cmd_write_o,
    output logic [31:0]     mem_cmd_addr_o,
    output logic [3:0]      mem_cmd_len_o,
    output logic            mem_wdata_valid_o,
    input  logic            mem_wdata_ready_i,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_wstrb_o,
    input  logic            mem_wack_i,
    input  logic            mem_rdata_valid_i,
    output logic            mem_rdata_ready_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    import nvdla_package::*;

    state_dbb_fsm_t  state_q, state_d;
    ctrl_dbb_req_t   req_q, req_d;
    ctrl_dbb_wdat_t  wdat_q, wdat_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            gnt_wr, gnt_rd, arb_update;
    logic            wbeat_hs, last_beat;
    flags_dbb_rdat_t rd_flags;

    nvdla_dbb_rr_arbiter u_arbiter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_wr_i    (wr_req_valid_i & enable_i & (state_q == FSM_DBB_IDLE)),
        .req_rd_i    (rd_req_valid_i & enable_i & (state_q == FSM_DBB_IDLE)),
        .update_i    (arb_update),
        .served_wr_i (req_q.write),
        .gnt_wr_o    (gnt_wr),
        .gnt_rd_o    (gnt_rd)
    );

    assign last_beat = (cnt_q == req_q.len);
    assign busy_o    = (state_q != FSM_DBB_IDLE);
    assign err_o     = err_q;

    always_comb begin
        state_d           = state_q;
        req_d             = req_q;
        wdat_d            = wdat_q;
        cnt_d             = cnt_q;
        err_d             = err_q;
        arb_update        = 1'b0;
        wbeat_hs          = 1'b0;
        rd_flags          = '0;
        wr_req_ready_o    = 1'b0;
        rd_req_ready_o    = 1'b0;
        wdat_ready_o      = 1'b0;
        wrsp_valid_o      = 1'b0;
        wrsp_id_o         = '0;
        rdat_valid_o      = 1'b0;
        rdat_data_o       = '0;
        rdat_last_o       = 1'b0;
        rdat_id_o         = '0;
        mem_cmd_valid_o   = 1'b0;
        mem_cmd_write_o   = 1'b0;
        mem_cmd_addr_o    = '0;
        mem_cmd_len_o     = '0;
        mem_wdata_valid_o = 1'b0;
        mem_wdata_o       = '0;
        mem_wstrb_o       = '0;
        mem_rdata_ready_o = 1'b0;
        done_o            = 1'b0;

        unique case (state_q)
            FSM_DBB_IDLE: begin
                wr_req_ready_o = gnt_wr;
                rd_req_ready_o = gnt_rd;
                if (gnt_wr) begin
                    req_d   = '{write: 1'b1, addr: wr_req_addr_i, len: wr_req_len_i,
                                id: wr_req_id_i};
                    state_d = FSM_WRITE;
                end else if (gnt_rd) begin
                    req_d   = '{write: 1'b0, addr: rd_req_addr_i, len: rd_req_len_i,
                                id: rd_req_id_i};
                    state_d = FSM_READ;
                end
            end
            FSM_WRITE, FSM_READ: begin
                mem_cmd_valid_o = 1'b1;
                mem_cmd_write_o = req_q.write;
                mem_cmd_addr_o  = req_q.addr;
                mem_cmd_len_o   = req_q.len;
                if (mem_wack_i && req_q.write) begin
                    wdat_d.wack_seen = 1'b1;
                end
                if (mem_cmd_ready_i) begin
                    state_d = req_q.write ? FSM_WAIT_WRITE : FSM_WAIT_READ;
                end
            end
            FSM_WAIT_WRITE: begin
                // Stop passing data once all beats are in; only the wack is awaited then.
                if (!wdat_q.beats_done) begin
                    mem_wdata_valid_o = wdat_valid_i;
                    wdat_ready_o      = mem_wdata_ready_i;
                    mem_wdata_o       = wdat_data_i;
                    mem_wstrb_o       = wdat_strb_i;
                    wbeat_hs          = wdat_valid_i & mem_wdata_ready_i;
                end
                if (mem_wack_i) begin
                    wdat_d.wack_seen = 1'b1;
                end
                if (wbeat_hs) begin
                    if (wdat_last_i != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        wdat_d.beats_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                if ((wdat_q.beats_done || (wbeat_hs && last_beat))
                    && (wdat_q.wack_seen || mem_wack_i)) begin
                    state_d = FSM_WRITE_RESPONSE;
                end
            end
            FSM_WRITE_RESPONSE: begin
                wrsp_valid_o = 1'b1;
                wrsp_id_o    = req_q.id;
                if (wrsp_ready_i) begin
                    state_d = FSM_DBB_TERMINATE;
                end
            end
            FSM_WAIT_READ: begin
                rd_flags.hs       = mem_rdata_valid_i & rdat_ready_i;
                rd_flags.last     = last_beat;
                rdat_valid_o      = mem_rdata_valid_i;
                mem_rdata_ready_o = rdat_ready_i;
                rdat_data_o       = mem_rdata_i;
                rdat_id_o         = req_q.id;
                rdat_last_o       = rd_flags.last;
                if (rd_flags.hs) begin
                    if (rd_flags.last) begin
                        state_d = FSM_DBB_TERMINATE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            FSM_DBB_TERMINATE: begin
                done_o     = 1'b1;
                arb_update = 1'b1;
                cnt_d      = '0;
                wdat_d     = '0;
                state_d    = FSM_DBB_IDLE;
            end
            default: begin
                state_d = FSM_DBB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FSM_DBB_IDLE;
            req_q   <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_nvdla_dbb_scheduler.sv
// Directed bench for nvdla_dbb_scheduler with a transaction-level expectation model.
module tb_nvdla_dbb_scheduler;

    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, enable_i;
    logic wr_req_valid_i, wr_req_ready_o;
    logic [31:0] wr_req_addr_i;
    logic [3:0] wr_req_len_i;
    logic [7:0] wr_req_id_i;
    logic wdat_valid_i, wdat_ready_o, wdat_last_i;
    logic [DW-1:0] wdat_data_i;
    logic [SW-1:0] wdat_strb_i;
    logic wrsp_valid_o, wrsp_ready_i;
    logic [7:0] wrsp_id_o;
    logic rd_req_valid_i, rd_req_ready_o;
    logic [31:0] rd_req_addr_i;
    logic [3:0] rd_req_len_i;
    logic [7:0] rd_req_id_i;
    logic rdat_valid_o, rdat_ready_i, rdat_last_o;
    logic [DW-1:0] rdat_data_o;
    logic [7:0] rdat_id_o;
    logic mem_cmd_valid_o, mem_cmd_ready_i, mem_cmd_write_o;
    logic [31:0] mem_cmd_addr_o;
    logic [3:0] mem_cmd_len_o;
    logic mem_wdata_valid_o, mem_wdata_ready_i, mem_wack_i;
    logic [DW-1:0] mem_wdata_o;
    logic [SW-1:0] mem_wstrb_o;
    logic mem_rdata_valid_i, mem_rdata_ready_o;
    logic [DW-1:0] mem_rdata_i;
    logic busy_o, done_o, err_o;

    nvdla_dbb_scheduler #(.DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
        .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i), .wr_req_id_i(wr_req_id_i),
        .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_data_i(wdat_data_i),
        .wdat_strb_i(wdat_strb_i), .wdat_last_i(wdat_last_i),
        .wrsp_valid_o(wrsp_valid_o), .wrsp_ready_i(wrsp_ready_i), .wrsp_id_o(wrsp_id_o),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i), .rd_req_id_i(rd_req_id_i),
        .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i), .rdat_data_o(rdat_data_o),
        .rdat_last_o(rdat_last_o), .rdat_id_o(rdat_id_o),
        .mem_cmd_valid_o(mem_cmd_valid_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_cmd_write_o(mem_cmd_write_o), .mem_cmd_addr_o(mem_cmd_addr_o),
        .mem_cmd_len_o(mem_cmd_len_o),
        .mem_wdata_valid_o(mem_wdata_valid_o), .mem_wdata_ready_i(mem_wdata_ready_i),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_wack_i(mem_wack_i),
        .mem_rdata_valid_i(mem_rdata_valid_i), .mem_rdata_ready_o(mem_rdata_ready_o),
        .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, expected event", name);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [DW-1:0] wpat(input logic [7:0] id, input int k);
        return {id, 24'hA5A5A5, 28'h0, 4'(k)};
    endfunction

    function automatic logic [DW-1:0] rpat(input logic [31:0] a, input int k);
        return {a + 32'(k), ~a};
    endfunction

    function automatic logic [SW-1:0] wstrb(input int k);
        logic [SW-1:0] s;
        s = '1;
        return s >> (k % 4);
    endfunction

    // ---------------- expectation model ----------------
    typedef struct { logic write; logic [31:0] addr; logic [3:0] len; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; } wbeat_t;
    typedef struct { logic [DW-1:0] data; logic last; logic [7:0] id; } rbeat_t;

    cmd_t       exp_cmd[$];
    wbeat_t     exp_wdat[$];
    logic [7:0] exp_wrsp[$];
    rbeat_t     exp_rdat[$];
    int         grant_log[$];
    bit         prio_rd_m = 1'b0;
    bit         err_m = 1'b0;
    bit         done_due = 1'b0;
    int         wr_len_m = 0, wr_k_m = 0;
    int         done_cnt = 0, rd_beats = 0, rd_lasts = 0;
    logic [7:0] last_wrsp_id = '0;

    // Memory-side events seen before each edge, consumed by the read responder after it.
    bit          s_rst = 1'b0, s_cmd_rd = 1'b0, s_mrd_hs = 1'b0;
    logic [31:0] s_addr = '0;
    logic [3:0]  s_len = '0;

    always @(negedge clk) begin
        cmd_t   c;
        wbeat_t wb;
        rbeat_t rb;
        s_rst    = rst_i;
        s_cmd_rd = mem_cmd_valid_o && mem_cmd_ready_i && !mem_cmd_write_o && !rst_i;
        s_addr   = mem_cmd_addr_o;
        s_len    = mem_cmd_len_o;
        s_mrd_hs = mem_rdata_valid_i && mem_rdata_ready_o && !rst_i;
        if (rst_i) begin
            exp_cmd.delete();
            exp_wdat.delete();
            exp_wrsp.delete();
            exp_rdat.delete();
            prio_rd_m = 1'b0;
            err_m     = 1'b0;
            done_due  = 1'b0;
        end else begin
            check("req_ready_onehot", 64'(wr_req_ready_o & rd_req_ready_o), 0);
            if (!enable_i) check("ready_while_disabled", 64'(wr_req_ready_o | rd_req_ready_o), 0);
            check("done_o", 64'(done_o), 64'(done_due));
            done_due = 1'b0;
            check("err_o", 64'(err_o), 64'(err_m));
            if (done_o) done_cnt++;
            if (wr_req_valid_i && wr_req_ready_o) begin
                if (rd_req_valid_i) check("arb_tie_write", 64'(prio_rd_m), 0);
                c.write = 1'b1; c.addr = wr_req_addr_i; c.len = wr_req_len_i;
                exp_cmd.push_back(c);
                exp_wrsp.push_back(wr_req_id_i);
                wr_len_m = int'(wr_req_len_i);
                wr_k_m   = 0;
                grant_log.push_back(1);
            end
            if (rd_req_valid_i && rd_req_ready_o) begin
                if (wr_req_valid_i) check("arb_tie_read", 64'(prio_rd_m), 1);
                c.write = 1'b0; c.addr = rd_req_addr_i; c.len = rd_req_len_i;
                exp_cmd.push_back(c);
                for (int k = 0; k <= int'(rd_req_len_i); k++) begin
                    rb.data = rpat(rd_req_addr_i, k);
                    rb.last = (k == int'(rd_req_len_i));
                    rb.id   = rd_req_id_i;
                    exp_rdat.push_back(rb);
                end
                grant_log.push_back(0);
            end
            if (mem_cmd_valid_o && mem_cmd_ready_i) begin
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_write", 64'(mem_cmd_write_o), 64'(c.write));
                    check("cmd_addr", 64'(mem_cmd_addr_o), 64'(c.addr));
                    check("cmd_len", 64'(mem_cmd_len_o), 64'(c.len));
                end
            end
            if (mem_wdata_valid_o && mem_wdata_ready_i) begin
                if (exp_wdat.size() == 0 || wr_k_m > wr_len_m) begin
                    check("wdata_unexpected", 1, 0);
                end else begin
                    wb = exp_wdat.pop_front();
                    check("wdata", mem_wdata_o, wb.data);
                    check("wstrb", 64'(mem_wstrb_o), 64'(wb.strb));
                    if (wdat_last_i != (wr_k_m == wr_len_m)) err_m = 1'b1;
                    wr_k_m++;
                end
            end
            if (wrsp_valid_o && wrsp_ready_i) begin
                if (exp_wrsp.size() == 0) begin
                    check("wrsp_unexpected", 1, 0);
                end else begin
                    check("wrsp_id", 64'(wrsp_id_o), 64'(exp_wrsp.pop_front()));
                end
                check("wrsp_after_all_beats", 64'(wr_k_m), 64'(wr_len_m + 1));
                last_wrsp_id = wrsp_id_o;
                done_due     = 1'b1;
                prio_rd_m    = 1'b1;
            end
            if (rdat_valid_o && rdat_ready_i) begin
                if (exp_rdat.size() == 0) begin
                    check("rdat_unexpected", 1, 0);
                end else begin
                    rb = exp_rdat.pop_front();
                    check("rdat_data", rdat_data_o, rb.data);
                    check("rdat_last", 64'(rdat_last_o), 64'(rb.last));
                    check("rdat_id", 64'(rdat_id_o), 64'(rb.id));
                    rd_beats++;
                    if (rdat_last_o) rd_lasts++;
                    if (rb.last) begin
                        done_due  = 1'b1;
                        prio_rd_m = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- memory read responder ----------------
    bit          rsp_active = 1'b0;
    logic [31:0] rsp_addr = '0;
    int          rsp_len = 0, rsp_k = 0;

    always @(posedge clk) begin
        #1;
        if (s_rst) begin
            rsp_active = 1'b0;
        end else begin
            if (s_mrd_hs) begin
                rsp_k++;
                if (rsp_k > rsp_len) rsp_active = 1'b0;
            end
            if (s_cmd_rd) begin
                rsp_active = 1'b1;
                rsp_addr   = s_addr;
                rsp_len    = int'(s_len);
                rsp_k      = 0;
            end
        end
        mem_rdata_valid_i = rsp_active;
        mem_rdata_i       = rpat(rsp_addr, rsp_k);
    end

    bit rd_toggle = 1'b0;
    always @(posedge clk) begin
        #1;
        rdat_ready_i = rd_toggle ? ~rdat_ready_i : 1'b1;
    end

    // ---------------- drivers ----------------
    task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [7:0] id,
                            input bit bad, input bit early);
        int     t;
        wbeat_t wb;
        wr_req_valid_i = 1'b1;
        wr_req_addr_i  = a;
        wr_req_len_i   = len;
        wr_req_id_i    = id;
        @(negedge clk);
        t = 0;
        while (!wr_req_ready_o && t < 300) begin @(negedge clk); t++; end
        if (!wr_req_ready_o) bail("wr_req_wait");
        @(posedge clk); #1;
        wr_req_valid_i = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wdat_valid_i = 1'b1;
            wdat_data_i  = wpat(id, k);
            wdat_strb_i  = wstrb(k);
            wdat_last_i  = bad ? (k == 0) : (k == int'(len));
            wb.data = wdat_data_i;
            wb.strb = wdat_strb_i;
            exp_wdat.push_back(wb);
            @(negedge clk);
            t = 0;
            while (!wdat_ready_o && t < 300) begin @(negedge clk); t++; end
            if (!wdat_ready_o) bail("wdat_wait");
            if (early && k == 0) mem_wack_i = 1'b1;
            @(posedge clk); #1;
            mem_wack_i = 1'b0;
        end
        wdat_valid_i = 1'b0;
        wdat_last_i  = 1'b0;
        if (!early) begin
            mem_wack_i = 1'b1;
            @(posedge clk); #1;
            mem_wack_i = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [7:0] id);
        int t;
        rd_req_valid_i = 1'b1;
        rd_req_addr_i  = a;
        rd_req_len_i   = len;
        rd_req_id_i    = id;
        @(negedge clk);
        t = 0;
        while (!rd_req_ready_o && t < 300) begin @(negedge clk); t++; end
        if (!rd_req_ready_o) bail("rd_req_wait");
        @(posedge clk); #1;
        rd_req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        @(negedge clk);
        t = 0;
        while ((busy_o || exp_cmd.size() != 0 || exp_wdat.size() != 0 || exp_wrsp.size() != 0
                || exp_rdat.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) bail("wait_idle");
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        bail("global_timeout");
    end

    initial begin
        int gsz;
        int t;
        rst_i = 1'b1; enable_i = 1'b1;
        wr_req_valid_i = 1'b0; wr_req_addr_i = '0; wr_req_len_i = '0; wr_req_id_i = '0;
        wdat_valid_i = 1'b0; wdat_data_i = '0; wdat_strb_i = '0; wdat_last_i = 1'b0;
        wrsp_ready_i = 1'b1;
        rd_req_valid_i = 1'b0; rd_req_addr_i = '0; rd_req_len_i = '0; rd_req_id_i = '0;
        rdat_ready_i = 1'b1;
        mem_cmd_ready_i = 1'b1; mem_wdata_ready_i = 1'b1; mem_wack_i = 1'b0;
        mem_rdata_valid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(busy_o), 0);
        check("rst_err", 64'(err_o), 0);
        check("rst_done", 64'(done_o), 0);
        check("rst_cmd_valid", 64'(mem_cmd_valid_o), 0);
        check("rst_wrsp_valid", 64'(wrsp_valid_o), 0);
        check("rst_rdat_valid", 64'(rdat_valid_o), 0);
        check("rst_wdata_out", mem_wdata_o, 0);
        check("rst_rdat_id", 64'(rdat_id_o), 0);
        @(posedge clk); #1;

        // Single write, wack one cycle after the last beat
        do_write(32'h1000, 4'd3, 8'h21, 1'b0, 1'b0);
        wait_idle();
        check("t1_wrsp_id", 64'(last_wrsp_id), 64'h21);
        check("t1_done_cnt", 64'(done_cnt), 1);

        // Read with toggling backpressure
        rd_toggle = 1'b1;
        rd_beats  = 0;
        rd_lasts  = 0;
        do_read(32'h2000, 4'd7, 8'h05);
        wait_idle();
        rd_toggle = 1'b0;
        check("t2_beats", 64'(rd_beats), 8);
        check("t2_last_count", 64'(rd_lasts), 1);
        check("t2_done_cnt", 64'(done_cnt), 2);

        // Protocol error: last flagged on beat 0 of a 2-beat write
        do_write(32'h3000, 4'd1, 8'h33, 1'b1, 1'b0);
        wait_idle();
        check("t3_err", 64'(err_o), 1);
        check("t3_wrsp_id", 64'(last_wrsp_id), 64'h33);
        check("t3_done_cnt", 64'(done_cnt), 3);

        // Disable mid-read, pending write must wait; then early-wack write
        do_read(32'h4000, 4'd3, 8'h44);
        enable_i = 1'b0;
        gsz = grant_log.size();
        fork
            begin
                repeat (20) @(posedge clk);
                #1;
                check("t4_read_done", 64'(done_cnt), 4);
                check("t4_no_grant_disabled", 64'(grant_log.size()), 64'(gsz));
                enable_i = 1'b1;
            end
            do_write(32'h5000, 4'd2, 8'h55, 1'b0, 1'b1);
        join
        wait_idle();
        check("t5_wrsp_id", 64'(last_wrsp_id), 64'h55);
        check("t5_done_cnt", 64'(done_cnt), 5);
        check("t5_err_sticky", 64'(err_o), 1);

        // Reset during WAIT_READ (tie priority is read at this point)
        rd_toggle = 1'b1;
        rd_beats  = 0;
        do_read(32'h6000, 4'd7, 8'h66);
        t = 0;
        while (rd_beats < 2 && t < 300) begin @(negedge clk); t++; end
        if (rd_beats < 2) bail("t6_beats_wait");
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        rd_toggle = 1'b0;
        @(negedge clk);
        check("t6_busy", 64'(busy_o), 0);
        check("t6_cmd_valid", 64'(mem_cmd_valid_o), 0);
        check("t6_rdat_valid", 64'(rdat_valid_o), 0);
        check("t6_wrsp_valid", 64'(wrsp_valid_o), 0);
        check("t6_wdata_valid", 64'(mem_wdata_valid_o), 0);
        check("t6_err_cleared", 64'(err_o), 0);
        check("t6_done_cnt", 64'(done_cnt), 5);
        @(posedge clk); #1;

        // Arbitration with both sides continuously requesting
        grant_log.delete();
        fork
            begin
                do_write(32'h7000, 4'd1, 8'h71, 1'b0, 1'b0);
                do_write(32'h7100, 4'd0, 8'h72, 1'b0, 1'b0);
            end
            begin
                do_read(32'h8000, 4'd1, 8'h73);
                do_read(32'h8100, 4'd2, 8'h74);
            end
        join
        wait_idle();
        check("t7_grants", 64'(grant_log.size()), 4);
        if (grant_log.size() == 4) begin
            check("t7_grant0_write", 64'(grant_log[0]), 1);
            check("t7_grant1_read", 64'(grant_log[1]), 0);
            check("t7_grant2_write", 64'(grant_log[2]), 1);
            check("t7_grant3_read", 64'(grant_log[3]), 0);
        end
        check("t7_done_cnt", 64'(done_cnt), 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
